// File: rtl/urt_rx_cmd_ctrl_pkg.sv
// Shared constants for the URT RX command controller: opcodes, FSM states,
// prescale code decode and link-config reset values.
package urt_pkg;

  localparam logic [7:0] OP_CFG = 8'hAA;
  localparam logic [7:0] OP_WR  = 8'hBB;
  localparam logic [7:0] OP_RD  = 8'hCC;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG_DATA = 3'd1,
    ST_WR_ADDR  = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_RD_ADDR  = 3'd4
  } state_t;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  localparam logic       RST_PAR_EN   = 1'b0;
  localparam logic       RST_PAR_TYP  = 1'b0;
  localparam logic [5:0] RST_PRESCALE = PRESC_8;

  // Code 2'b11 has no ratio assigned; a CFG frame carrying it is rejected.
  function automatic logic presc_code_legal(input logic [1:0] code);
    return code != 2'b11;
  endfunction

  function automatic logic [5:0] presc_decode(input logic [1:0] code);
    case (code)
      2'b00:   return PRESC_8;
      2'b01:   return PRESC_16;
      2'b10:   return PRESC_32;
      default: return PRESC_8;
    endcase
  endfunction

endpackage

// File: rtl/urt_rx_cmd_ctrl_if.sv
// Byte stream from the URT receiver and strobes toward the register file.
// master = the RX/register-file side, slave = the command controller.
interface urt_rx_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_data_valid;
  logic              rx_err;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wr_data;

  modport master (
    output rx_data, rx_data_valid, rx_err,
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data
  );

  modport slave (
    input  rx_data, rx_data_valid, rx_err,
    output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data
  );
endinterface

// File: rtl/urt_gap_timer.sv
// Inter-byte gap timer. Down-counter reloaded with limit-1 while cleared;
// expired is asserted on the cycle the count reaches zero while enabled,
// so the owner acts exactly i_limit clocks after the last clear.
module urt_gap_timer #(
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Reload on clear, otherwise count down to zero and hold there.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= i_limit - 1'b1;
    else if (i_en && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/urt_rx_cmd_ctrl.sv
// Command/configuration controller behind the URT receiver.
//
//  state       | meaning
//  ST_IDLE     | waiting for an opcode byte
//  ST_CFG_DATA | OP_CFG seen, waiting for the link-config byte
//  ST_WR_ADDR  | OP_WR seen, waiting for the register address
//  ST_WR_DATA  | address latched, waiting for write data
//  ST_RD_ADDR  | OP_RD seen, waiting for the register address
//
// Every output is registered, so a response shows up one clock after the
// byte that caused it. An rx_err beats a coincident valid byte; a valid byte
// beats a coincident gap timeout.
module urt_rx_cmd_ctrl
  import urt_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  CLK,
  input  logic                  RST,
  urt_rx_cmd_ctrl_if.slave      bus,
  output logic                  PAR_EN,
  output logic                  PAR_TYP,
  output logic [5:0]            Prescale,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  cmd_err
);

  // Sized for the slowest link so the product below can never wrap.
  localparam int CNT_W = $clog2(TIMEOUT_BITS * 32 + 1);

  state_t            r_state, w_state_nxt;
  logic              r_par_en, w_par_en_nxt;
  logic              r_par_typ, w_par_typ_nxt;
  logic [5:0]        r_prescale, w_prescale_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic              r_frame_err, w_frame_err_nxt;
  logic              r_cmd_err, w_cmd_err_nxt;
  logic              r_busy;

  logic              w_byte;
  logic              w_expired;
  logic              w_tmr_clr;
  logic              w_tmr_en;
  logic [CNT_W-1:0]  w_limit;

  assign w_byte    = bus.rx_data_valid && !bus.rx_err;
  assign w_tmr_en  = (r_state != ST_IDLE);
  assign w_tmr_clr = (r_state == ST_IDLE) || bus.rx_data_valid;
  assign w_limit   = CNT_W'(TIMEOUT_BITS) * CNT_W'(r_prescale);

  urt_gap_timer #(.CNT_W(CNT_W)) u_gap_timer (
    .CLK       (CLK),
    .RST       (RST),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .i_limit   (w_limit),
    .o_expired (w_expired)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_par_en_nxt    = r_par_en;
    w_par_typ_nxt   = r_par_typ;
    w_prescale_nxt  = r_prescale;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_cmd_err_nxt   = 1'b0;

    if (r_state == ST_IDLE) begin
      if (w_byte) begin
        if (bus.rx_data == DATA_W'(OP_CFG))
          w_state_nxt = ST_CFG_DATA;
        else if (bus.rx_data == DATA_W'(OP_WR))
          w_state_nxt = ST_WR_ADDR;
        else if (bus.rx_data == DATA_W'(OP_RD))
          w_state_nxt = ST_RD_ADDR;
        else
          w_cmd_err_nxt = 1'b1;
      end
    end else if (bus.rx_err) begin
      w_frame_err_nxt = 1'b1;
      w_state_nxt     = ST_IDLE;
    end else if (bus.rx_data_valid) begin
      case (r_state)
        ST_CFG_DATA: begin
          if (presc_code_legal(bus.rx_data[3:2])) begin
            w_par_en_nxt   = bus.rx_data[0];
            w_par_typ_nxt  = bus.rx_data[1];
            w_prescale_nxt = presc_decode(bus.rx_data[3:2]);
          end else begin
            w_frame_err_nxt = 1'b1;
          end
          w_state_nxt = ST_IDLE;
        end
        ST_WR_ADDR: begin
          w_addr_nxt  = bus.rx_data[ADDR_W-1:0];
          w_state_nxt = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          w_wdata_nxt = bus.rx_data;
          w_wr_en_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_RD_ADDR: begin
          w_addr_nxt  = bus.rx_data[ADDR_W-1:0];
          w_rd_en_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_expired) begin
      w_frame_err_nxt = 1'b1;
      w_state_nxt     = ST_IDLE;
    end
  end

  // Output registers; link config only ever changes as one unit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_en    <= RST_PAR_EN;
      r_par_typ   <= RST_PAR_TYP;
      r_prescale  <= RST_PRESCALE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_par_en    <= w_par_en_nxt;
      r_par_typ   <= w_par_typ_nxt;
      r_prescale  <= w_prescale_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign PAR_EN          = r_par_en;
  assign PAR_TYP         = r_par_typ;
  assign Prescale        = r_prescale;
  assign busy            = r_busy;
  assign frame_err       = r_frame_err;
  assign cmd_err         = r_cmd_err;
  assign bus.reg_wr_en   = r_wr_en;
  assign bus.reg_rd_en   = r_rd_en;
  assign bus.reg_addr    = r_addr;
  assign bus.reg_wr_data = r_wdata;

endmodule

// File: tb/tb_urt_rx_cmd_ctrl.sv
// Scoreboard bench for urt_rx_cmd_ctrl: the stimulus pushes hand-computed
// expected responses; a monitor pops one whenever the DUT shows a strobe,
// an error flag or a busy falling edge.
module tb_urt_rx_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PAR_EN, PAR_TYP;
  logic [5:0] Prescale;
  logic       busy, frame_err, cmd_err;

  urt_rx_cmd_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  urt_rx_cmd_ctrl #(.DATA_W(8), .ADDR_W(8), .TIMEOUT_BITS(20)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .busy      (busy),
    .frame_err (frame_err),
    .cmd_err   (cmd_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       wr, rd, fe, ce, pe, pt;
    logic [5:0] presc;
    logic [7:0] addr, wd;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  function automatic exp_t mk(input logic wr, rd, fe, ce, pe, pt,
                              input logic [5:0] presc, input logic [7:0] addr, wd);
    exp_t e;
    e.cyc = 0; e.wr = wr; e.rd = rd; e.fe = fe; e.ce = ce; e.pe = pe; e.pt = pt;
    e.presc = presc; e.addr = addr; e.wd = wd;
    return e;
  endfunction

  task automatic drive(input logic [7:0] b, input logic err, input bit has,
                       input int lat, input exp_t x);
    exp_t y;
    @(negedge CLK);
    bus.rx_data = b; bus.rx_data_valid = 1'b1; bus.rx_err = err;
    if (has) begin
      y = x; y.cyc = cyc + lat; q.push_back(y);
    end
    @(negedge CLK);
    bus.rx_data_valid = 1'b0; bus.rx_err = 1'b0;
  endtask

  task automatic byte_only(input logic [7:0] b, input logic err);
    drive(b, err, 1'b0, 0, mk(0,0,0,0,0,0,6'd0,8'h00,8'h00));
  endtask

  task automatic byte_exp(input logic [7:0] b, input logic err, input int lat, input exp_t x);
    drive(b, err, 1'b1, lat, x);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: one comparison per observed DUT response.
  initial begin
    logic busy_q;
    logic ev;
    exp_t x;
    busy_q = 1'b0;
    forever begin
      @(negedge CLK);
      ev = bus.reg_wr_en | bus.reg_rd_en | frame_err | cmd_err | (busy_q & ~busy);
      if (mon_en && ev) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d wr=%b rd=%b fe=%b ce=%b busy=%b",
                   cyc, bus.reg_wr_en, bus.reg_rd_en, frame_err, cmd_err, busy);
        end else begin
          x = q.pop_front();
          if (cyc != x.cyc || bus.reg_wr_en !== x.wr || bus.reg_rd_en !== x.rd ||
              frame_err !== x.fe || cmd_err !== x.ce || PAR_EN !== x.pe ||
              PAR_TYP !== x.pt || Prescale !== x.presc || bus.reg_addr !== x.addr ||
              bus.reg_wr_data !== x.wd || busy !== 1'b0) begin
            fails++;
            $display("FAIL event got cyc=%0d wr=%b rd=%b fe=%b ce=%b pe=%b pt=%b presc=%0d addr=%h wd=%h busy=%b exp cyc=%0d wr=%b rd=%b fe=%b ce=%b pe=%b pt=%b presc=%0d addr=%h wd=%h busy=0",
                     cyc, bus.reg_wr_en, bus.reg_rd_en, frame_err, cmd_err, PAR_EN, PAR_TYP,
                     Prescale, bus.reg_addr, bus.reg_wr_data, busy,
                     x.cyc, x.wr, x.rd, x.fe, x.ce, x.pe, x.pt, x.presc, x.addr, x.wd);
          end
        end
      end
      busy_q = busy;
    end
  end

  initial begin
    exp_t r;
    bus.rx_data = 8'h00; bus.rx_data_valid = 1'b0; bus.rx_err = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    tests++;
    if (PAR_EN !== 1'b0 || PAR_TYP !== 1'b0 || Prescale !== 6'd8 || bus.reg_addr !== 8'h00 ||
        bus.reg_wr_data !== 8'h00 || bus.reg_wr_en !== 1'b0 || bus.reg_rd_en !== 1'b0 ||
        busy !== 1'b0 || frame_err !== 1'b0 || cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got pe=%b pt=%b presc=%0d addr=%h wd=%h busy=%b exp pe=0 pt=0 presc=8 addr=00 wd=00 busy=0",
               PAR_EN, PAR_TYP, Prescale, bus.reg_addr, bus.reg_wr_data, busy);
    end
    RST = 1'b0;
    mon_en = 1'b1;
    gap(2);

    // CFG 05: parity on, even, x16
    byte_only(8'hAA, 0);
    byte_exp(8'h05, 0, 1, mk(0,0,0,0, 1,0,6'd16, 8'h00,8'h00));
    // register write
    byte_only(8'hBB, 0); byte_only(8'h3C, 0);
    byte_exp(8'hA5, 0, 1, mk(1,0,0,0, 1,0,6'd16, 8'h3C,8'hA5));
    // register read
    byte_only(8'hCC, 0);
    byte_exp(8'h07, 0, 1, mk(0,1,0,0, 1,0,6'd16, 8'h07,8'hA5));
    // CFG 0B: parity on, odd, x32
    byte_only(8'hAA, 0);
    byte_exp(8'h0B, 0, 1, mk(0,0,0,0, 1,1,6'd32, 8'h07,8'hA5));
    // timeout at x32: 20*32 clocks after the opcode is consumed
    byte_exp(8'hBB, 0, 1 + 640, mk(0,0,1,0, 1,1,6'd32, 8'h07,8'hA5));
    gap(650);
    // back to defaults
    byte_only(8'hAA, 0);
    byte_exp(8'h00, 0, 1, mk(0,0,0,0, 0,0,6'd8, 8'h07,8'hA5));
    // unknown opcode
    byte_exp(8'h55, 0, 1, mk(0,0,0,1, 0,0,6'd8, 8'h07,8'hA5));
    // illegal prescale code: config untouched
    byte_only(8'hAA, 0);
    byte_exp(8'h0C, 0, 1, mk(0,0,1,0, 0,0,6'd8, 8'h07,8'hA5));
    // timeout at x8: 160 clocks
    byte_exp(8'hBB, 0, 1 + 160, mk(0,0,1,0, 0,0,6'd8, 8'h07,8'hA5));
    gap(170);
    byte_only(8'hBB, 0); byte_only(8'h01, 0);
    byte_exp(8'h02, 0, 1, mk(1,0,0,0, 0,0,6'd8, 8'h01,8'h02));
    // byte arriving on the very cycle the timer expires wins
    byte_only(8'hBB, 0);
    gap(158);
    byte_only(8'h11, 0);
    byte_exp(8'h22, 0, 1, mk(1,0,0,0, 0,0,6'd8, 8'h11,8'h22));
    // rx_err in IDLE: opcode discarded silently, next frame parses cleanly
    byte_only(8'hBB, 1);
    byte_only(8'hCC, 0);
    byte_exp(8'h05, 0, 1, mk(0,1,0,0, 0,0,6'd8, 8'h05,8'h22));
    // rx_err with valid in WR_DATA: abort, no write
    byte_only(8'hBB, 0); byte_only(8'h10, 0);
    byte_exp(8'h33, 1, 1, mk(0,0,1,0, 0,0,6'd8, 8'h10,8'h22));
    // reset mid-frame after a config change
    byte_only(8'hAA, 0);
    byte_exp(8'h05, 0, 1, mk(0,0,0,0, 1,0,6'd16, 8'h10,8'h22));
    byte_only(8'hBB, 0); byte_only(8'h20, 0);
    #2;
    r = mk(0,0,0,0, 0,0,6'd8, 8'h00,8'h00);
    r.cyc = cyc + 1;
    q.push_back(r);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    gap(1);
    byte_only(8'hBB, 0); byte_only(8'h01, 0);
    byte_exp(8'h02, 0, 1, mk(1,0,0,0, 0,0,6'd8, 8'h01,8'h02));

    gap(5);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d pending responses, exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
